// File: rtl/mc_datapath_regs.sv
// mc_datapath_regs
//   Non-architectural register and PC-update stage of the multicycle RV32I
//   core. It holds PC, OldPC, Instr, Data, A, WriteData and ALUOut, resolves
//   conditional branches from the ALU flags, and drives the unified memory
//   address and the Result bus.
//
// Ports
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   IRWrite              load Instr <= ReadData and OldPC <= PC
//   PCUpdate             unconditional PC write
//   Branch               conditional PC write, resolved on Instr[14:12]
//   ResultSrc[1:0]       Result select: 0 ALUOut, 1 Data, 2/3 ALUResult
//   AdrSrc               memory address select: 0 PC, 1 Result
//   ReadData[31:0]       memory read data
//   RD1, RD2[31:0]       register-file read ports
//   ALUResult[31:0]      combinational ALU output
//   Zero/Neg/Carry/Ovf   ALU flags of SrcA-SrcB (Carry=1 means no borrow)
//   PC, OldPC[31:0]      program counter / PC of the current instruction
//   Instr[31:0]          registered instruction
//   Data[31:0]           registered ReadData
//   A, WriteData[31:0]   registered RD1 / RD2
//   ALUOut[31:0]         registered ALUResult
//   Result[31:0]         ResultSrc mux output (combinational)
//   Adr[31:0]            memory address (combinational)
//   PCWrite              PCUpdate | (Branch & taken) (combinational)
//   MisalignErr          sticky flag, set when a PC write targets a
//                        non-word-aligned address
module mc_datapath_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        IRWrite,
  input  logic        PCUpdate,
  input  logic        Branch,
  input  logic [1:0]  ResultSrc,
  input  logic        AdrSrc,
  input  logic [31:0] ReadData,
  input  logic [31:0] RD1,
  input  logic [31:0] RD2,
  input  logic [31:0] ALUResult,
  input  logic        Zero,
  input  logic        Neg,
  input  logic        Carry,
  input  logic        Ovf,
  output logic [31:0] PC,
  output logic [31:0] OldPC,
  output logic [31:0] Instr,
  output logic [31:0] Data,
  output logic [31:0] A,
  output logic [31:0] WriteData,
  output logic [31:0] ALUOut,
  output logic [31:0] Result,
  output logic [31:0] Adr,
  output logic        PCWrite,
  output logic        MisalignErr
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] old_pc_q, old_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] data_q, a_q, wd_q, alu_out_q;
  logic        misalign_q, misalign_d;
  logic [31:0] result;
  logic        taken;
  logic        pc_write;

  always_comb begin
    result = ALUResult;
    case (ResultSrc)
      2'd0:    result = alu_out_q;
      2'd1:    result = data_q;
      default: result = ALUResult;
    endcase
  end

  // Flags come from SrcA-SrcB: signed less-than is Neg^Ovf, unsigned
  // less-than is a borrow, i.e. !Carry.
  always_comb begin
    taken = 1'b0;
    case (instr_q[14:12])
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = Neg ^ Ovf;
      3'b101:  taken = ~(Neg ^ Ovf);
      3'b110:  taken = ~Carry;
      3'b111:  taken = Carry;
      default: taken = 1'b0;
    endcase
  end

  assign pc_write = PCUpdate | (Branch & taken);

  always_comb begin
    pc_d       = pc_q;
    old_pc_d   = old_pc_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
    if (IRWrite) begin
      old_pc_d = pc_q;
      instr_d  = ReadData;
    end
    // Bit 0 is always cleared; bit 1 set flags the error but the PC still
    // loads so the core keeps running and software can inspect the flag.
    if (pc_write) begin
      pc_d = {result[31:1], 1'b0};
      if (result[1]) misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      old_pc_q   <= RESET_PC;
      instr_q    <= NOP_INSTR;
      data_q     <= '0;
      a_q        <= '0;
      wd_q       <= '0;
      alu_out_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      old_pc_q   <= old_pc_d;
      instr_q    <= instr_d;
      data_q     <= ReadData;
      a_q        <= RD1;
      wd_q       <= RD2;
      alu_out_q  <= ALUResult;
      misalign_q <= misalign_d;
    end
  end

  assign PC          = pc_q;
  assign OldPC       = old_pc_q;
  assign Instr       = instr_q;
  assign Data        = data_q;
  assign A           = a_q;
  assign WriteData   = wd_q;
  assign ALUOut      = alu_out_q;
  assign Result      = result;
  assign Adr         = AdrSrc ? result : pc_q;
  assign PCWrite     = pc_write;
  assign MisalignErr = misalign_q;

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Testbench for mc_datapath_regs: directed scenarios with literal
// expectations, then randomized stimulus compared every cycle against a
// behavioural model of the register stage.
module tb_mc_datapath_regs;

  logic        clock = 1'b0;
  logic        reset;
  logic        IRWrite, PCUpdate, Branch, AdrSrc;
  logic [1:0]  ResultSrc;
  logic [31:0] ReadData, RD1, RD2, ALUResult;
  logic        Zero, Neg, Carry, Ovf;
  logic [31:0] PC, OldPC, Instr, Data, A, WriteData, ALUOut, Result, Adr;
  logic        PCWrite, MisalignErr;

  int checks = 0;
  int errors = 0;

  mc_datapath_regs dut (
    .clock(clock), .reset(reset), .IRWrite(IRWrite), .PCUpdate(PCUpdate),
    .Branch(Branch), .ResultSrc(ResultSrc), .AdrSrc(AdrSrc),
    .ReadData(ReadData), .RD1(RD1), .RD2(RD2), .ALUResult(ALUResult),
    .Zero(Zero), .Neg(Neg), .Carry(Carry), .Ovf(Ovf),
    .PC(PC), .OldPC(OldPC), .Instr(Instr), .Data(Data), .A(A),
    .WriteData(WriteData), .ALUOut(ALUOut), .Result(Result), .Adr(Adr),
    .PCWrite(PCWrite), .MisalignErr(MisalignErr)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_oldpc, m_instr, m_data, m_a, m_wd, m_aluout;
  logic        m_mis;

  function automatic logic [31:0] m_result();
    if (ResultSrc == 2'd0) return m_aluout;
    if (ResultSrc == 2'd1) return m_data;
    return ALUResult;
  endfunction

  // Branch condition of the current instruction, in terms of the comparison
  // it encodes (BEQ, BNE, BLT, BGE, BLTU, BGEU).
  function automatic logic m_taken();
    logic eq, lt_s, lt_u;
    eq   = Zero;
    lt_s = (Neg != Ovf);
    lt_u = !Carry;
    case (m_instr[14:12])
      3'd0: return eq;
      3'd1: return !eq;
      3'd4: return lt_s;
      3'd5: return !lt_s;
      3'd6: return lt_u;
      3'd7: return !lt_u;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_pcwrite();
    return PCUpdate || (Branch && m_taken());
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pc = 32'h0; m_oldpc = 32'h0; m_instr = 32'h13;
      m_data = 0; m_a = 0; m_wd = 0; m_aluout = 0; m_mis = 0;
    end else begin
      logic [31:0] res;
      logic        wr;
      res = m_result();
      wr  = m_pcwrite();
      if (IRWrite) begin
        m_oldpc = m_pc;
        m_instr = ReadData;
      end
      if (wr) begin
        m_pc = res - (res % 2);
        if (res[1]) m_mis = 1'b1;
      end
      m_data = ReadData; m_a = RD1; m_wd = RD2; m_aluout = ALUResult;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, well after the inputs settle.
  always @(negedge clock) begin
    #2;
    if (!reset) begin
      chk("model.PC", PC, m_pc);
      chk("model.OldPC", OldPC, m_oldpc);
      chk("model.Instr", Instr, m_instr);
      chk("model.Data", Data, m_data);
      chk("model.A", A, m_a);
      chk("model.WriteData", WriteData, m_wd);
      chk("model.ALUOut", ALUOut, m_aluout);
      chk("model.Result", Result, m_result());
      chk("model.Adr", Adr, AdrSrc ? m_result() : m_pc);
      chk("model.PCWrite", {31'b0, PCWrite}, {31'b0, m_pcwrite()});
      chk("model.MisalignErr", {31'b0, MisalignErr}, {31'b0, m_mis});
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    IRWrite = 0; PCUpdate = 0; Branch = 0; AdrSrc = 0; ResultSrc = 2'd0;
    ReadData = 0; RD1 = 0; RD2 = 0; ALUResult = 0;
    Zero = 0; Neg = 0; Carry = 1; Ovf = 0;
  endtask

  task automatic load_instr(input logic [31:0] ins, input logic [31:0] alu);
    @(negedge clock);
    idle();
    IRWrite = 1; ReadData = ins; ALUResult = alu;
    @(posedge clock); #1;
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;
    #1;
    chk("reset.PC", PC, 32'h0);
    chk("reset.OldPC", OldPC, 32'h0);
    chk("reset.Instr", Instr, 32'h13);
    chk("reset.Misalign", {31'b0, MisalignErr}, 32'h0);

    // FETCH from 0x100
    @(negedge clock);
    idle(); PCUpdate = 1; ResultSrc = 2'd2; ALUResult = 32'h100;
    @(posedge clock); #1;
    chk("setup.PC", PC, 32'h100);
    @(negedge clock);
    idle(); IRWrite = 1; PCUpdate = 1; ResultSrc = 2'd2;
    ReadData = 32'h0050_0093; ALUResult = 32'h104;
    @(posedge clock); #1;
    chk("fetch.PC", PC, 32'h104);
    chk("fetch.OldPC", OldPC, 32'h100);
    chk("fetch.Instr", Instr, 32'h0050_0093);

    // BNE taken to ALUOut=0x80, then not taken with Zero=1
    load_instr(32'h0000_1063, 32'h80);
    @(negedge clock);
    idle(); Branch = 1; Zero = 0; ResultSrc = 2'd0; ALUResult = 32'h200;
    #1 chk("bne.PCWrite", {31'b0, PCWrite}, 32'h1);
    @(posedge clock); #1;
    chk("bne.PC", PC, 32'h80);
    @(negedge clock);
    idle(); Branch = 1; Zero = 1; ResultSrc = 2'd0;
    #1 chk("bne_nt.PCWrite", {31'b0, PCWrite}, 32'h0);
    @(posedge clock); #1;
    chk("bne_nt.PC", PC, 32'h80);

    // BLT with Neg=Ovf=1 -> not taken; BLTU with Carry=0 -> taken
    load_instr(32'h0000_4063, 32'h300);
    @(negedge clock);
    idle(); Branch = 1; Neg = 1; Ovf = 1;
    #1 chk("blt.PCWrite", {31'b0, PCWrite}, 32'h0);
    @(posedge clock); #1;
    chk("blt.PC", PC, 32'h80);
    load_instr(32'h0000_6063, 32'h340);
    @(negedge clock);
    idle(); Branch = 1; Carry = 0;
    #1 chk("bltu.PCWrite", {31'b0, PCWrite}, 32'h1);
    @(posedge clock); #1;
    chk("bltu.PC", PC, 32'h340);

    // Misaligned target: PC loads, flag sticks
    @(negedge clock);
    idle(); PCUpdate = 1; ResultSrc = 2'd2; ALUResult = 32'h102;
    @(posedge clock); #1;
    chk("mis.PC", PC, 32'h102);
    chk("mis.flag", {31'b0, MisalignErr}, 32'h1);
    @(negedge clock); idle();
    repeat (10) @(posedge clock);
    #1 chk("mis.sticky", {31'b0, MisalignErr}, 32'h1);

    // Load path
    @(negedge clock);
    idle(); ALUResult = 32'h2000;
    @(negedge clock);
    idle(); AdrSrc = 1; ResultSrc = 2'd0; ReadData = 32'hCAFE_F00D;
    #1 chk("load.Adr", Adr, 32'h2000);
    @(posedge clock); #1;
    chk("load.Data", Data, 32'hCAFE_F00D);
    @(negedge clock);
    idle(); ResultSrc = 2'd1; ReadData = 32'h1234_5678;
    #1 chk("load.Result", Result, 32'hCAFE_F00D);

    // Reset mid-cycle takes effect without a clock edge
    @(posedge clock); #1;
    reset = 1;
    #1;
    chk("midreset.PC", PC, 32'h0);
    chk("midreset.Instr", Instr, 32'h13);
    chk("midreset.Misalign", {31'b0, MisalignErr}, 32'h0);
    @(negedge clock);
    reset = 0;

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 99) == 0) begin
        #1 reset = 1;
        @(negedge clock);
        reset = 0;
      end
      IRWrite   = $urandom_range(0, 3) == 0;
      PCUpdate  = $urandom_range(0, 3) == 0;
      Branch    = $urandom_range(0, 2) == 0;
      AdrSrc    = $urandom_range(0, 1);
      ResultSrc = 2'($urandom_range(0, 3));
      ReadData  = $urandom;
      ALUResult = $urandom;
      // Keep most targets word-aligned so the sticky flag is not always set.
      if ($urandom_range(0, 7) != 0) begin
        ReadData[1]  = 1'b0;
        ALUResult[1] = 1'b0;
      end
      RD1   = $urandom;
      RD2   = $urandom;
      Zero  = $urandom_range(0, 1);
      Neg   = $urandom_range(0, 1);
      Carry = $urandom_range(0, 1);
      Ovf   = $urandom_range(0, 1);
    end
    @(negedge clock);
    idle();
    @(negedge clock);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
